// File: rtl/cdc_tx_pkg.sv
// Shared types and constants for the req/ack crossing source controller.
// State enum and round-robin pointer width helper.
package cdc_tx_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StRelease = 2'd2
    } cdc_tx_state_e;

    localparam int unsigned CDC_TX_N_DEFAULT = 4;

    function automatic int unsigned rr_ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CDC_TX_RR_W = rr_ptr_width(CDC_TX_N_DEFAULT);

endpackage

// File: rtl/synchronizer.sv
// Three-flop level synchronizer for signals entering this clock domain.
// All stages clear on the asynchronous active-high reset.
module synchronizer #(
    parameter int unsigned DW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] r_meta;
    logic [DW-1:0] r_sync;
    logic [DW-1:0] r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_out  <= '0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
            r_out  <= r_sync;
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Source side of a four-phase req/ack crossing shared round-robin by N clients.
// Define CDC_TX_TIMEOUT_EN to build the sticky acknowledge watchdog (timeout_err).
module cdc_tx_arbiter
    import cdc_tx_pkg::*;
#(
    parameter int unsigned DW             = 32,
    parameter int unsigned N              = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    client_req,
    input  logic [N*DW-1:0] client_data,
    output logic [N-1:0]    client_grant,
    output logic            xfer_req,
    output logic [DW-1:0]   xfer_data,
    input  logic            xfer_ack_async,
    output logic            busy,
    output logic            timeout_err
);

    localparam int unsigned PW = rr_ptr_width(N);

    logic          w_ack_sync;
    cdc_tx_state_e r_state;
    cdc_tx_state_e w_state_d;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] w_rr_ptr_d;
    logic          r_xfer_req;
    logic [DW-1:0] r_xfer_data;
    logic [DW-1:0] w_sel_data;
    logic [N-1:0]  w_pick;
    logic [N-1:0]  w_grant;

    synchronizer #(
        .DW(1)
    ) u_ack_sync (
        .clk    (clk),
        .reset  (reset),
        .i_data (xfer_ack_async),
        .o_data (w_ack_sync)
    );

    // First requester found scanning upward from ptr, wrapping N-1 -> 0.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
        logic [N-1:0] gnt;
        logic         found;
        int unsigned  slot;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            slot = (32'(ptr) + k) % N;
            for (int unsigned j = 0; j < N; j++) begin
                if (!found && (j == slot) && req[j]) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

    always_comb begin
        w_pick    = rr_pick(client_req, r_rr_ptr);
        w_state_d = r_state;
        w_grant   = '0;
        case (r_state)
            StIdle: begin
                // A lingering ack from the far side must clear before a new request.
                if (!w_ack_sync && (|w_pick)) begin
                    w_grant   = w_pick;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (w_ack_sync) begin
                    w_state_d = StRelease;
                end
            end
            StRelease: begin
                if (!w_ack_sync) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_sel_data = '0;
        w_rr_ptr_d = r_rr_ptr;
        for (int unsigned j = 0; j < N; j++) begin
            if (w_grant[j]) begin
                w_sel_data = client_data[j*DW +: DW];
                w_rr_ptr_d = PW'((j + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_xfer_req  <= 1'b0;
            r_xfer_data <= '0;
        end else begin
            r_state  <= w_state_d;
            r_rr_ptr <= w_rr_ptr_d;
            if (|w_grant) begin
                r_xfer_req  <= 1'b1;
                r_xfer_data <= w_sel_data;
            end else if ((r_state == StReq) && w_ack_sync) begin
                r_xfer_req <= 1'b0;
            end
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wd_cnt;
    logic          r_timeout_err;

    // Counter saturates at the limit; the FSM keeps waiting for the ack regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (|w_grant) begin
            r_wd_cnt <= '0;
        end else if (r_state == StReq) begin
            if (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                r_timeout_err <= 1'b1;
            end
            if (r_wd_cnt != CW'(TIMEOUT_CYCLES)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // Grant is combinational; mask it so reset forces every output low at once.
    assign client_grant = w_grant & {N{~reset}};
    assign xfer_req     = r_xfer_req;
    assign xfer_data    = r_xfer_data;
    assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter: transfer-level model plus directed scenarios.
// Expectations for timeout_err follow CDC_TX_TIMEOUT_EN.
module tb_cdc_tx_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int TO = 16;
`ifdef CDC_TX_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic            clk            = 1'b0;
    logic            reset          = 1'b0;
    logic [N-1:0]    client_req     = '0;
    logic [N*DW-1:0] client_data    = '0;
    logic            xfer_ack_async = 1'b0;
    logic [N-1:0]    client_grant;
    logic            xfer_req;
    logic [DW-1:0]   xfer_data;
    logic            busy;
    logic            timeout_err;

    cdc_tx_arbiter #(
        .DW             (DW),
        .N              (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .client_req     (client_req),
        .client_data    (client_data),
        .client_grant   (client_grant),
        .xfer_req       (xfer_req),
        .xfer_data      (xfer_data),
        .xfer_ack_async (xfer_ack_async),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    bit chk_en    = 1'b0;
    bit auto_drop = 1'b0;
    int hi_cycles = 0;
    int obs_log[$];
    int m_log[$];

    // Transfer-level model: phase 0 idle, 1 awaiting ack high, 2 awaiting ack low.
    int            m_phase = 0;
    int            m_ptr   = 0;
    bit            m_req   = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [2:0]    m_hist  = '0;
    int            m_cnt   = 0;
    bit            m_terr  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_ptr   <= 0;
            m_req   <= 1'b0;
            m_data  <= '0;
            m_hist  <= '0;
            m_cnt   <= 0;
            m_terr  <= 1'b0;
        end else begin
            m_hist <= {m_hist[1:0], xfer_ack_async};
            case (m_phase)
                0: if (!m_hist[2] && pick(client_req, m_ptr) >= 0) begin
                    m_phase <= 1;
                    m_req   <= 1'b1;
                    m_cnt   <= 0;
                    m_ptr   <= (pick(client_req, m_ptr) + 1) % N;
                    m_data  <= client_data[pick(client_req, m_ptr)*DW +: DW];
                    m_log.push_back(pick(client_req, m_ptr));
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (TimeoutOn && (m_cnt + 1 == TO)) m_terr <= 1'b1;
                    if (m_hist[2]) begin
                        m_req   <= 1'b0;
                        m_phase <= 2;
                    end
                end
                default: if (!m_hist[2]) m_phase <= 0;
            endcase
        end
    end

    task automatic compare_cycle();
        logic [N-1:0] eg;
        int p;
        eg = '0;
        p  = pick(client_req, m_ptr);
        if (!reset && m_phase == 0 && !m_hist[2] && p >= 0) eg[p] = 1'b1;
        check("client_grant", 64'(client_grant), 64'(eg));
        check("xfer_req", 64'(xfer_req), 64'(m_req));
        check("busy", 64'(busy), 64'(m_phase != 0));
        check("timeout_err", 64'(timeout_err), 64'(m_terr));
        if (m_req) check("xfer_data", 64'(xfer_data), 64'(m_data));
        for (int j = 0; j < N; j++) if (client_grant[j]) obs_log.push_back(j);
        if (xfer_req) hi_cycles++;
    endtask

    always @(negedge clk) if (chk_en) compare_cycle();

    // A granted client withdraws its request after the latching edge.
    task automatic drop_granted();
        logic [N-1:0] g;
        g = client_grant;
        #1;
        client_req = client_req & ~g;
    endtask

    always @(posedge clk) if (auto_drop && !reset) drop_granted();

    task automatic wait_xfer(input logic level, input string name);
        int n;
        n = 0;
        while (xfer_req !== level && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(xfer_req), 64'(level));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic far_ack(input int rise_dly, input int fall_dly);
        wait_xfer(1'b1, "xfer_req_rise");
        repeat (rise_dly) begin @(posedge clk); #1; end
        xfer_ack_async = 1'b1;
        wait_xfer(1'b0, "xfer_req_fall");
        repeat (fall_dly) begin @(posedge clk); #1; end
        xfer_ack_async = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, mb, h0, d, rise;
        int exp_fair[6] = '{0, 1, 2, 3, 0, 1};

        #1 reset = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_xfer_req", 64'(xfer_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(client_grant), 64'd0);
        check("rst_timeout", 64'(timeout_err), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Fairness: all clients request continuously.
        for (int i = 0; i < N; i++) client_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
        ob = obs_log.size();
        mb = m_log.size();
        client_req = '1;
        repeat (6) far_ack(1, 1);
        client_req = '0;
        wait_idle();
        check("fair_count", 64'(obs_log.size() - ob), 64'd6);
        if (obs_log.size() >= ob + 6 && m_log.size() >= mb + 6) begin
            for (int k = 0; k < 6; k++) begin
                check("fair_order", 64'(obs_log[ob+k]), 64'(exp_fair[k]));
                check("model_fair_order", 64'(m_log[mb+k]), 64'(exp_fair[k]));
            end
        end
        auto_drop = 1'b1;

        // Single transfer from client 2.
        client_data[2*DW +: DW] = 32'hA5A5_0002;
        ob = obs_log.size();
        h0 = hi_cycles;
        client_req = 4'b0100;
        far_ack(2, 2);
        wait_idle();
        check("single_data", 64'(xfer_data), 64'hA5A5_0002);
        check("single_req_cycles", 64'(hi_cycles - h0), 64'd6);
        check("single_grants", 64'(obs_log.size() - ob), 64'd1);
        if (obs_log.size() > ob) check("single_client", 64'(obs_log[ob]), 64'd2);

        // Wrap: pointer now at 3, clients 1 and 3 request.
        client_data[1*DW +: DW] = 32'h0BAD_0001;
        client_data[3*DW +: DW] = 32'h0BAD_0003;
        ob = obs_log.size();
        client_req = 4'b1010;
        far_ack(1, 1);
        far_ack(1, 1);
        wait_idle();
        check("wrap_grants", 64'(obs_log.size() - ob), 64'd2);
        if (obs_log.size() >= ob + 2) begin
            check("wrap_first", 64'(obs_log[ob]), 64'd3);
            check("wrap_second", 64'(obs_log[ob+1]), 64'd1);
        end

        // Stale ack held high out of reset.
        reset = 1'b1;
        xfer_ack_async = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        ob = obs_log.size();
        client_req = 4'b0001;
        repeat (6) begin @(posedge clk); #1; end
        check("stale_no_grant", 64'(obs_log.size() - ob), 64'd0);
        xfer_ack_async = 1'b0;
        d = 0;
        while (d < 20 && !client_grant[0]) begin
            @(posedge clk);
            #1;
            d++;
        end
        check("stale_delay", 64'(d), 64'd3);
        far_ack(1, 1);
        wait_idle();

        // Reset five cycles into REQ.
        ob = obs_log.size();
        client_req = 4'b0010;
        wait_xfer(1'b1, "mid_rst_req_rise");
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        client_req = 4'b1001;
        #1;
        check("mid_rst_xfer_req", 64'(xfer_req), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_grant", 64'(client_grant), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("rst_prio_grant", 64'(client_grant), 64'b0001);
        far_ack(1, 1);
        far_ack(1, 1);
        wait_idle();
        check("rst_grants", 64'(obs_log.size() - ob), 64'd3);
        if (obs_log.size() >= ob + 3) begin
            check("rst_after_first", 64'(obs_log[ob+1]), 64'd0);
            check("rst_after_second", 64'(obs_log[ob+2]), 64'd3);
        end

        // Watchdog: ack withheld, then delivered late.
        ob = obs_log.size();
        client_req = 4'b0010;
        wait_xfer(1'b1, "to_req_rise");
        rise = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (timeout_err && rise == 0) rise = i;
        end
        check("timeout_rise", 64'(rise), TimeoutOn ? 64'd16 : 64'd0);
        xfer_ack_async = 1'b1;
        wait_xfer(1'b0, "to_req_fall");
        @(posedge clk);
        #1 xfer_ack_async = 1'b0;
        wait_idle();
        check("timeout_sticky", 64'(timeout_err), 64'(TimeoutOn));
        check("timeout_grants", 64'(obs_log.size() - ob), 64'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
